// File: rtl/sw_debounce_pkg.sv
// Shared types and default constants for the switch debouncer.
package sw_debounce_pkg;

  // Per-bit debounce FSM encoding
  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } db_state_e;

  // 1 ms at 50 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEFAULT_SYNC_STAGES     = 2;

endpackage : sw_debounce_pkg

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchronizer chain, STABLE/CHECK FSM and stability counter.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic sw_raw,
  input  logic pulse_en,
  output logic sw_clean,
  output logic sw_changed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   changed_q, changed_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Next-state: shift synchronizer, qualify a new level over a full window
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], sw_raw};
    state_d   = state_q;
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    changed_d = 1'b0;
    case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (s != clean_q) begin
          state_d = CHECK;
          cnt_d   = CNT_W'(1);
        end
      end
      CHECK: begin
        if (s == clean_q) begin
          // bounce: drop back and restart the window on the next change
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = STABLE;
          cnt_d     = '0;
          clean_d   = s;
          changed_d = pulse_en;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q    <= '0;
      state_q   <= STABLE;
      cnt_q     <= '0;
      clean_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      changed_q <= changed_d;
    end
  end

  assign sw_clean   = clean_q;
  assign sw_changed = changed_q;

endmodule : sw_debounce_bit

// File: rtl/sw_debounce.sv
// Debounces WIDTH board switches and flags when the outputs have settled after reset.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed,
  output logic             sw_valid
);

  localparam int unsigned SETTLE  = SYNC_STAGES + DEBOUNCE_CYCLES;
  localparam int unsigned START_W = $clog2(SETTLE + 1);
  localparam logic [START_W-1:0] START_LAST = START_W'(SETTLE - 1);

  logic [START_W-1:0] start_q, start_d;
  logic               valid_q, valid_d;

  // Per-bit debouncers; change pulses suppressed until settled
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_bit (
      .clock      (clock),
      .reset      (reset),
      .sw_raw     (sw_raw[i]),
      .pulse_en   (valid_q),
      .sw_clean   (sw_clean[i]),
      .sw_changed (sw_changed[i])
    );
  end

  // Startup settle counter; stops once valid is reached
  always_comb begin
    start_d = start_q;
    valid_d = valid_q;
    if (!valid_q) begin
      start_d = start_q + START_W'(1);
      if (start_q == START_LAST) begin
        valid_d = 1'b1;
      end
    end
  end

  // Settle register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q <= '0;
      valid_q <= 1'b0;
    end else begin
      start_q <= start_d;
      valid_q <= valid_d;
    end
  end

  assign sw_valid = valid_q;

endmodule : sw_debounce
